// File: rtl/uart_tx_fifo.sv
//------------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte FIFO and issue controller that sits directly upstream of uart_tx.
// A producer pushes bytes at full clock rate. The controller then hands the
// bytes to the transmitter one at a time through the wr_en / byte / tx_empty
// handshake, so the producer never has to poll the UART.
//
// Parameters
//   DEPTH        FIFO capacity in bytes (power of two, >= 2)
//   ACK_TIMEOUT  cycles to wait for tx_empty to fall after a load pulse (>= 1)
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous, active-high reset
//   wr_en     in   push strobe, one byte per accepted cycle
//   din       in   byte to push
//   full      out  count == DEPTH (registered)
//   empty     out  count == 0 (registered)
//   count     out  bytes currently stored
//   overflow  out  sticky, set by a push attempted while full
//   tx_empty  in   from uart_tx: transmitter idle and ready
//   tx_wr_en  out  to uart_tx wr_en: single-cycle load pulse
//   tx_byte   out  to uart_tx byte: held stable between loads
//------------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    // producer side
    input  logic                     wr_en,
    input  logic [7:0]               din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    // uart_tx side
    input  logic                     tx_empty,
    output logic                     tx_wr_en,
    output logic [7:0]               tx_byte
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,   // waiting for data and an idle transmitter
        LOAD,   // load pulse to uart_tx is high in this cycle
        ACK,    // waiting for uart_tx to take the byte (tx_empty falls)
        BUSY    // frame in flight, waiting for tx_empty to rise again
    } state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TW-1:0]   ack_timer;
    logic [CW-1:0]   count_next;
    logic            push;
    logic            pop;

    //--------------------------------------------------------------------------
    // Handshake decode
    //--------------------------------------------------------------------------
    // A push is judged against the count at the start of the cycle, so a pop
    // in the same cycle never frees a slot for it.
    assign push = wr_en && !full;

    // The only pop is the IDLE -> LOAD transition. Because tx_empty is
    // required here, the LOAD cycle always follows a cycle in which the
    // transmitter was seen idle.
    assign pop = (state == IDLE) && !empty && tx_empty;

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so that no path leaves it unassigned and infers a latch.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Storage
    //--------------------------------------------------------------------------
    // NOTE: the data array is deliberately left out of reset. A flush only
    // needs the pointers and count cleared, and a reset-free array can map
    // onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    //--------------------------------------------------------------------------
    // Pointers, occupancy and flags
    //--------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples pre-edge values, whatever order the blocks run in.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;    // wraps naturally at DEPTH
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            // Flags are registered from the next count, so they line up with count.
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Issue FSM, with registered load pulse and output byte
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx_wr_en  <= 1'b0;
            tx_byte   <= 8'h00;
            ack_timer <= '0;
        end else begin
            tx_wr_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        tx_byte  <= mem[rd_ptr];
                        tx_wr_en <= 1'b1;
                        state    <= LOAD;
                    end
                end

                LOAD: begin
                    ack_timer <= '0;
                    state     <= ACK;
                end

                // If the transmitter never acknowledges, the byte still counts
                // as issued. It is not re-popped, and the FIFO moves on.
                ACK: begin
                    if (!tx_empty) begin
                        state <= BUSY;
                    end else if (ack_timer == TW'(ACK_TIMEOUT - 1)) begin
                        state <= IDLE;
                    end else begin
                        ack_timer <= ack_timer + 1'b1;
                    end
                end

                BUSY: begin
                    if (tx_empty) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
//------------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed bench for uart_tx_fifo. A small behavioural transmitter stands in
// for uart_tx. It accepts a load pulse, drops tx_empty on the next cycle,
// holds it low for FRAME_LEN cycles and collapses on rst. Every load pulse is
// logged with its byte and cycle number. Expected values are hand-derived
// constants.
//------------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DEPTH       = 16;
    localparam int ACK_TIMEOUT = 4;
    localparam int FRAME_LEN   = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  din;
    logic        full;
    logic        empty;
    logic [4:0]  count;
    logic        overflow;
    logic        tx_empty;
    logic        tx_wr_en;
    logic [7:0]  tx_byte;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    logic        model_en;
    logic        model_busy;
    logic        force_busy;

    logic [7:0]  pulse_byte[$];
    int          pulse_cyc[$];
    logic [7:0]  exp_q[$];
    logic        prev_wr = 1'b0;
    logic        prev_te = 1'b1;
    int          max_count = 0;

    assign tx_empty = !(model_busy || force_busy);

    uart_tx_fifo #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .din      (din),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_empty (tx_empty),
        .tx_wr_en (tx_wr_en),
        .tx_byte  (tx_byte)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Compares the logged load pulses against exp_q, in order.
    task automatic check_stream(input string tag);
        check({tag, "_pulses"}, 32'(pulse_byte.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < pulse_byte.size()) begin
                check($sformatf("%s_byte%0d", tag, i), 32'(pulse_byte[i]), 32'(exp_q[i]));
            end
        end
    endtask

    task automatic clear_log();
        pulse_byte.delete();
        pulse_cyc.delete();
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        din   = b;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    // Pulse monitor: logs each load. It also checks that a load never repeats
    // on consecutive cycles and only ever follows a cycle in which the
    // transmitter was seen idle.
    always @(negedge clk) begin
        if (tx_wr_en === 1'b1) begin
            check("wr_no_b2b", 32'(prev_wr), 32'd0);
            check("wr_after_idle", 32'(prev_te), 32'd1);
            pulse_byte.push_back(tx_byte);
            pulse_cyc.push_back(cyc);
        end
        prev_wr = (tx_wr_en === 1'b1);
        prev_te = (tx_empty === 1'b1);
        if (count > max_count) max_count = int'(count);
    end

    // Behavioural transmitter.
    initial begin
        model_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (model_en && tx_wr_en === 1'b1) begin
                @(posedge clk);
                #1 model_busy = 1'b1;
                for (int i = 0; i < FRAME_LEN; i++) begin
                    @(posedge clk);
                    if (rst) break;
                end
                #1 model_busy = 1'b0;
            end
        end
    end

    initial begin
        rst        = 1'b1;
        wr_en      = 1'b0;
        din        = 8'h00;
        force_busy = 1'b0;
        model_en   = 1'b1;

        // ---------------- reset then idle ----------------
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_full",     32'(full),     32'd0);
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_count",    32'(count),    32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_tx_wr_en", 32'(tx_wr_en), 32'd0);
        check("rst_tx_byte",  32'(tx_byte),  32'h00);
        repeat (1000) @(posedge clk);
        #1;
        check("idle_no_pulse", 32'(pulse_byte.size()), 32'd0);

        // ---------------- single byte, 2-cycle latency ----------------
        clear_log();
        push(8'hF2);
        @(negedge clk);
        check("single_count", 32'(count), 32'd1);
        check("single_empty", 32'(empty), 32'd0);
        @(negedge clk);
        check("single_wr_en", 32'(tx_wr_en), 32'd1);
        check("single_byte",  32'(tx_byte),  32'hF2);
        repeat (30) @(posedge clk);
        #1;
        exp_q = {8'hF2};
        check_stream("single");
        check("single_byte_held", 32'(tx_byte), 32'hF2);

        // ---------------- burst of 5 ----------------
        clear_log();
        max_count = 0;
        for (int i = 1; i <= 5; i++) push(8'(i));
        repeat (100) @(posedge clk);
        #1;
        check("burst_peak_count", 32'(max_count), 32'd4);
        exp_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_stream("burst");
        // tx_empty rises 13 cycles after a load; the next load comes 2 later.
        if (pulse_cyc.size() >= 2) begin
            check("burst_gap", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd15);
        end
        check("burst_empty", 32'(empty), 32'd1);

        // ---------------- fill / overflow with transmitter busy ----------------
        clear_log();
        force_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i));
        @(negedge clk);
        check("fill16_full",     32'(full),     32'd1);
        check("fill16_count",    32'(count),    32'd16);
        check("fill16_overflow", 32'(overflow), 32'd0);
        push(8'hEE);
        @(negedge clk);
        check("fill17_overflow", 32'(overflow), 32'd1);
        check("fill17_count",    32'(count),    32'd16);
        check("fill17_full",     32'(full),     32'd1);
        check("fill_no_pulse",   32'(pulse_byte.size()), 32'd0);
        @(posedge clk);
        #1 force_busy = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(8'h10 + i));
        check_stream("drain");
        check("drain_empty",    32'(empty),    32'd1);
        check("drain_count",    32'(count),    32'd0);
        check("drain_overflow", 32'(overflow), 32'd1);

        // ---------------- ack timeout: transmitter never responds ----------------
        clear_log();
        model_en = 1'b0;
        push(8'h33);
        push(8'h44);
        repeat (20) @(posedge clk);
        #1;
        exp_q = {8'h33, 8'h44};
        check_stream("timeout");
        // LOAD, 4 ACK cycles, IDLE, then the next LOAD.
        if (pulse_cyc.size() >= 2) begin
            check("timeout_gap", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd6);
        end
        check("timeout_count", 32'(count), 32'd0);
        model_en = 1'b1;

        // ---------------- simultaneous push and pop at count 3 ----------------
        clear_log();
        force_busy = 1'b1;
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        check("simul_pre_count", 32'(count), 32'd3);
        force_busy = 1'b0;
        push(8'hA4);
        @(negedge clk);
        check("simul_count", 32'(count),    32'd3);
        check("simul_load",  32'(tx_wr_en), 32'd1);
        repeat (80) @(posedge clk);
        #1;
        exp_q = {8'hA1, 8'hA2, 8'hA3, 8'hA4};
        check_stream("simul");

        // ---------------- reset mid-frame ----------------
        for (int i = 0; i < 5; i++) push(8'(8'hB1 + i));
        check("midrst_pre_count", 32'(count), 32'd4);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        clear_log();
        @(negedge clk);
        check("midrst_count",    32'(count),    32'd0);
        check("midrst_empty",    32'(empty),    32'd1);
        check("midrst_full",     32'(full),     32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_tx_wr_en", 32'(tx_wr_en), 32'd0);
        check("midrst_tx_byte",  32'(tx_byte),  32'h00);
        push(8'hA5);
        @(negedge clk);
        check("post_rst_count", 32'(count), 32'd1);
        @(negedge clk);
        check("post_rst_wr_en", 32'(tx_wr_en), 32'd1);
        check("post_rst_byte",  32'(tx_byte),  32'hA5);
        repeat (30) @(posedge clk);
        #1;
        exp_q = {8'hA5};
        check_stream("post_rst");
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
